pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
Run controller for a programmable serial pattern detector. Holds a pattern of up to MAX_LEN bits and scans an incoming bit stream under a valid/ready handshake. Counts matches, overlapping by default, and stops once a programmed target count is reached. It sits between a config/host interface and a serial bit source, replacing fixed-pattern detector FSMs.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter and target

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  load cfg_pattern/cfg_len/cfg_target (honoured only in IDLE or DONE)
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit expected, bit 0 the last
cfg_len  in  $clog2(MAX_LEN)+1  pattern length, valid range 1..MAX_LEN
cfg_target  in  CNT_W  match count that ends the run; 0 = free-run until abort
start  in  1  begin a run (sampled in IDLE or DONE)
abort  in  1  end a run immediately
bit_valid  in  1  source has bit_in
bit_in  in  1  serial data bit
bit_ready  out  1  controller accepts a bit this cycle
match  out  1  one-cycle pulse per detected pattern
match_count  out  CNT_W  matches in the current or last run
busy  out  1  state is ARM or SCAN
done  out  1  state is DONE (level)

Behaviour:
- Reset (async): state IDLE; all outputs 0; pattern, len, target, history and fill registers cleared.
- States:
  - IDLE: start with a valid len -> ARM. Start with len 0 or len > MAX_LEN is ignored.
  - ARM: clear history, fill counter and match_count -> SCAN. Lasts exactly 1 cycle.
  - SCAN: bit_ready=1.
  - DONE: start (valid len) -> ARM.
- Latency: bit_ready rises 2 cycles after start is sampled.
- abort in any state: -> IDLE on the next edge; match_count is held. If start and abort are both asserted, abort wins.
- Accept: a bit is accepted when bit_valid && bit_ready. History shifts left with the new bit into bit 0. Fill counter increments and saturates at MAX_LEN.
- Match condition: fill+1 >= len and the low len bits of the updated history equal the low len bits of the pattern.
  - match pulses and match_count increments on the same edge that accepts the completing bit. Both are registered, visible the cycle after the handshake.
  - Overlapping matches are counted: pattern 101 on stream 10101 gives 2 matches.
- Termination: if target != 0 and the increment makes match_count == target, move to DONE on that same edge. bit_ready is 0 from the next cycle, so no bit is accepted after the final match.
- target == 0: match_count saturates at all-ones and never wraps. The run ends only by abort.
- Config: cfg_we in ARM or SCAN is ignored. Config changes in DONE take effect on the next start.
- No acceptance when bit_valid=0: history and fill are unchanged.
- reset mid-run: immediate IDLE, everything cleared, including config.

Optional Feature:
NONOVERLAP_EN
- Defined: after each match the fill counter is cleared (history bits are masked by fill), so matches cannot share bits. Pattern 101 on stream 10101 gives 1 match; on 101101 it gives 2.
- Undefined: overlapping detection as in Behaviour.

Decomposition:
- Package pattern_scan_pkg: state enum IDLE/ARM/SCAN/DONE (2-bit), plus a localparam LEN_W = $clog2(MAX_LEN)+1.
- Sub-module pattern_match_core: history shift register, fill counter and len-masked compare. Inputs: shift, clear, pattern, len. Output: hit (combinational on the next-history value).
- The top level holds the FSM, config registers, counter and handshake.

Test Plan:
1. Pattern 3'b101, len 3, target 2, stream 1,0,1,0,1 with bit_valid held high -> match pulses after bit 3 and bit 5; match_count=2; done=1; bit_ready=0 afterwards; a 6th valid bit is not accepted.
2. Same config, bit_valid toggling 1,0,1,0… with stream 1,1,0,1 -> exactly 1 match. Idle cycles must not shift history.
3. len 4, pattern 4'b1111, target 0, stream of 8 ones -> 5 matches; busy stays 1 until abort; after abort, IDLE with count held at 5.
4. start and abort asserted together in IDLE -> remains IDLE. start with len 0 -> remains IDLE, bit_ready never rises.
5. Async reset pulsed mid-SCAN, between clock edges -> outputs 0 immediately. cfg_we during SCAN with a new pattern -> ignored; the current run uses the old pattern.
6. Build with NONOVERLAP_EN, pattern 101, target 0, stream 1,0,1,0,1,1,0,1 -> 2 matches. Without the macro -> 3 matches.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// Shared types for the programmable serial pattern scanner.
package pattern_scan_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int LEN_W       = $clog2(MAX_LEN_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic len_valid(input int unsigned len, input int unsigned max_len);
        return (len != 0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/pattern_scan_ctrl_core.sv
// History shift register, fill counter and length-masked compare.
// NONOVERLAP_EN: clear the fill count after each hit so matches never share bits.
module pattern_match_core #(
    parameter  int MAX_LEN = 8,
    localparam int LW      = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_shift,
    input  logic               i_clear,
    input  logic               i_bit,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LW-1:0]      i_len,
    output logic               o_hit
);

    localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN);

    logic [MAX_LEN-1:0] r_hist;
    logic [LW-1:0]      r_fill;
    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [MAX_LEN-1:0] w_mask;
    logic [LW:0]        w_fill_p1;

    always_comb begin
        w_hist_nxt = {r_hist[MAX_LEN-2:0], i_bit};
        w_fill_p1  = {1'b0, r_fill} + (LW+1)'(1);
        w_mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(i_len));
        end
        // Hit is evaluated on the history as it will be after this bit shifts in.
        o_hit = i_shift && (w_fill_p1 >= {1'b0, i_len})
                && (((w_hist_nxt ^ i_pattern) & w_mask) == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_hist_nxt;
`ifdef NONOVERLAP_EN
            if (o_hit) begin
                r_fill <= '0;
            end else if (r_fill != FILL_MAX) begin
                r_fill <= w_fill_p1[LW-1:0];
            end
`else
            if (r_fill != FILL_MAX) begin
                r_fill <= w_fill_p1[LW-1:0];
            end
`endif
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Run controller for a programmable serial pattern detector: FSM, config, match counter.
// NONOVERLAP_EN (in pattern_match_core) selects non-overlapping match counting.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter  int MAX_LEN = MAX_LEN_DEF,
    parameter  int CNT_W   = 8,
    localparam int LW      = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               bit_ready,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LW-1:0]      r_len;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_count;
    logic               r_match;
    logic               w_cfg_open;
    logic               w_start_ok;
    logic               w_accept;
    logic               w_hit;
    logic               w_last;

    assign w_cfg_open = (r_state == IDLE) || (r_state == DONE);
    assign w_start_ok = start && !abort && len_valid(32'(r_len), MAX_LEN);
    assign w_accept   = bit_valid && (r_state == SCAN);
    // Final match of a bounded run: leave SCAN on the same edge so no further bit is taken.
    assign w_last     = w_accept && w_hit && (r_target != '0)
                        && ((r_count + CNT_ONE) == r_target);

    pattern_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .i_shift   (w_accept),
        .i_clear   (r_state == ARM),
        .i_bit     (bit_in),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .o_hit     (w_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start_ok) w_state_nxt = ARM;
                ARM:     w_state_nxt = SCAN;
                SCAN:    if (w_last) w_state_nxt = DONE;
                DONE:    if (w_start_ok) w_state_nxt = ARM;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bit_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ARM:     busy = 1'b1;
            SCAN: begin
                busy      = 1'b1;
                bit_ready = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_target  <= '0;
        end else if (cfg_we && w_cfg_open) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_target  <= cfg_target;
        end
    end

    // Free-running count saturates; a bounded run stops at target before it could wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= w_accept && w_hit;
            if (r_state == ARM) begin
                r_count <= '0;
            end else if (w_accept && w_hit && (r_count != CNT_MAX)) begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

    assign match       = r_match;
    assign match_count = r_count;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl with a queue scoreboard of expected match pulses.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort;
    logic       bit_valid;
    logic       bit_in;
    logic       bit_ready;
    logic       match;
    logic [7:0] match_count;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_pat;
    int         m_len;
    int         m_target;
    int         m_count;
    logic       m_run;
    logic       m_bits[$];
    logic       sb_q[$];

    pattern_scan_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .bit_ready   (bit_ready),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference: keep the received bits and compare the most recent m_len against the pattern.
    task automatic model_push(input logic b, output logic hit);
        int n;
        m_bits.push_back(b);
        if (m_bits.size() > 16) void'(m_bits.pop_front());
        n   = m_bits.size();
        hit = 1'b0;
        if (n >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++)
                if (m_bits[n - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
        end
        if (hit) begin
`ifdef NONOVERLAP_EN
            m_bits.delete();
`endif
            if (m_count != 255) m_count++;
            if (m_target != 0 && m_count == m_target) m_run = 1'b0;
        end
    endtask

    task automatic model_clear();
        m_pat = '0; m_len = 0; m_target = 0; m_count = 0; m_run = 1'b0;
        m_bits.delete();
        sb_q.delete();
    endtask

    // One cycle of stream stimulus; expected pulse pushed on acceptance, popped after the edge.
    task automatic step(input logic v, input logic b);
        logic acc, hit, e;
        bit_valid = v;
        bit_in    = b;
        @(negedge clk);
        n_checks++;
        if (bit_ready !== m_run) $display("FAIL bit_ready: got %b expected %b", bit_ready, m_run);
        else n_pass++;
        acc = v && m_run;
        if (acc) begin
            model_push(b, hit);
            sb_q.push_back(hit);
        end
        @(posedge clk); #1;
        e = 1'b0;
        if (acc) e = sb_q.pop_front();
        n_checks++;
        if (match !== e) $display("FAIL match_pulse: got %b expected %b", match, e);
        else n_pass++;
        bit_valid = 1'b0;
    endtask

    task automatic cfg_load(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
        cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_pat = p; m_len = int'(l); m_target = int'(t);
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        m_run = 1'b1; m_count = 0; m_bits.delete();
    endtask

    task automatic abort_run();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        m_run = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({bit_ready, match, match_count, busy, done} !== 12'h0)
            $display("FAIL reset_outputs: got %h expected 000", {bit_ready, match, match_count, busy, done});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_idle: got %b expected 00", {busy, done});
        else n_pass++;
    endtask

    task automatic test_overlap_target();
        logic [5:0] s = 6'b101011;
        cfg_load(8'b101, 4'd3, 8'd2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if ({busy, bit_ready} !== 2'b10) $display("FAIL arm_cycle: got %b expected 10", {busy, bit_ready});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bit_ready !== 1'b1) $display("FAIL ready_latency: got %b expected 1", bit_ready);
        else n_pass++;
        m_run = 1'b1; m_count = 0; m_bits.delete();
        for (int i = 5; i >= 0; i--) step(1'b1, s[i]);
        n_checks++;
        if (match_count !== 8'd2) $display("FAIL target_count: got %0d expected 2", match_count);
        else n_pass++;
        n_checks++;
        if ({done, busy} !== 2'b10) $display("FAIL target_done: got %b expected 10", {done, busy});
        else n_pass++;
    endtask

    task automatic test_valid_gaps();
        logic [6:0] v = 7'b1011001;
        logic [6:0] b = 7'b1010011;
        start_run();
        for (int i = 6; i >= 0; i--) step(v[i], b[i]);
        n_checks++;
        if (match_count !== 8'd1) $display("FAIL gap_count: got %0d expected 1", match_count);
        else n_pass++;
        abort_run();
        n_checks++;
        if ({busy, done, match_count} !== 10'd1) $display("FAIL gap_abort: got %h expected 001", {busy, done, match_count});
        else n_pass++;
    endtask

    task automatic test_free_run();
        cfg_load(8'b1111, 4'd4, 8'd0);
        start_run();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        n_checks++;
        if (match_count !== 8'd5) $display("FAIL free_count: got %0d expected 5", match_count);
        else n_pass++;
        step(1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL free_busy: got %b expected 1", busy);
        else n_pass++;
        abort_run();
        n_checks++;
        if ({busy, done, match_count} !== 10'd5) $display("FAIL free_abort: got %h expected 005", {busy, done, match_count});
        else n_pass++;
    endtask

    task automatic test_start_guard();
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL start_abort: got busy %b expected 0", busy);
        else n_pass++;
        cfg_load(8'b101, 4'd0, 8'd0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy, bit_ready} !== 2'b00) $display("FAIL len0_start: got %b expected 00", {busy, bit_ready});
            else n_pass++;
        end
        start = 1'b0;
        cfg_load(8'b101, 4'd9, 8'd0);
        start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if ({busy, bit_ready} !== 2'b00) $display("FAIL len9_start: got %b expected 00", {busy, bit_ready});
        else n_pass++;
    endtask

    task automatic test_reset_and_cfg_lock();
        logic [4:0] s = 5'b10111;
        cfg_load(8'b101, 4'd3, 8'd0);
        start_run();
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bit_ready, match, match_count, busy, done} !== 12'h0)
            $display("FAIL async_reset: got %h expected 000", {bit_ready, match, match_count, busy, done});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(posedge clk); #1;
        cfg_load(8'b101, 4'd3, 8'd0);
        start_run();
        cfg_pattern = 8'b111; cfg_we = 1'b1;
        for (int i = 4; i >= 0; i--) step(1'b1, s[i]);
        cfg_we = 1'b0;
        n_checks++;
        if (match_count !== 8'd1) $display("FAIL cfg_locked: got %0d expected 1", match_count);
        else n_pass++;
        abort_run();
    endtask

    task automatic test_nonoverlap();
        logic [7:0] s = 8'b10101101;
        int exp_cnt;
`ifdef NONOVERLAP_EN
        exp_cnt = 2;
`else
        exp_cnt = 3;
`endif
        cfg_load(8'b101, 4'd3, 8'd0);
        start_run();
        for (int i = 7; i >= 0; i--) step(1'b1, s[i]);
        n_checks++;
        if (int'(match_count) !== exp_cnt) $display("FAIL overlap_mode_count: got %0d expected %0d", match_count, exp_cnt);
        else n_pass++;
        abort_run();
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
        start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        model_clear();
        test_reset();
        test_overlap_target();
        test_valid_gaps();
        test_free_run();
        test_start_guard();
        test_reset_and_cfg_lock();
        test_nonoverlap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
